panel_switch_conditioner: RTL and testbench

//  Front-panel switch conditioner directly upstream of the CPU's sw_* control inputs.

---
 rtl/panel_pkg.sv | 17 +
 rtl/switch_debounce.sv | 50 +++++
 rtl/panel_switch_conditioner.sv | 107 ++++++++++
 tb/tb_panel_switch_conditioner.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared switch indices and default timing constants for the
// front-panel switch conditioner.
package panel_pkg;

    localparam int SW_CLEAR = 0;
    localparam int SW_RUN   = 1;
    localparam int SW_HALT  = 2;
    localparam int SW_STEPM = 3;
    localparam int SW_STEPI = 4;
    localparam int NUM_SW   = 5;

    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam int          DEF_CLEAR_LEN       = 32;
    localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd6000000;
    localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd1000000;

endpackage

// File: rtl/switch_debounce.sv
// One panel switch: 2-FF sync, debounce counter, stable level, press strobe.
// Ports: clk, rst (sync, high), btn_n (raw, active-low), held (stable level), press (1-cycle strobe).
module switch_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic held,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 16'd2) ?
                        $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 16'd1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic          prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            prev   <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= ~btn_n;
            s2    <= s1;
            prev  <= stable;
            // strobe lags the stable edge by one cycle
            press <= stable & ~prev;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign held = stable;

endmodule

// File: rtl/panel_switch_conditioner.sv
// Front-panel switch conditioner: debounced single-cycle CPU switch pulses and stretched CLEAR.
// Ports: SYSCLK, RESET (sync, high), btn_n[4:0], sw_CLEAR/RUN/HALT/STEPM/STEPI, sw_held[4:0].
// Optional macro PANEL_AUTOREPEAT_EN adds auto-repeat on STEPM/STEPI.
module panel_switch_conditioner
    import panel_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int          CLEAR_LEN       = DEF_CLEAR_LEN,
    parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              SYSCLK,
    input  logic              RESET,
    input  logic [NUM_SW-1:0] btn_n,
    output logic              sw_CLEAR,
    output logic              sw_RUN,
    output logic              sw_HALT,
    output logic              sw_STEPM,
    output logic              sw_STEPI,
    output logic [NUM_SW-1:0] sw_held
);

    localparam int CLW = $clog2(CLEAR_LEN + 1);

    logic [NUM_SW-1:0] held;
    logic [NUM_SW-1:0] press;
    logic [1:0]        rep_fire;
    logic [CLW-1:0]    clr_cnt;
    logic              clr_next;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (SYSCLK),
            .rst  (RESET),
            .btn_n(btn_n[i]),
            .held (held[i]),
            .press(press[i])
        );
    end

`ifdef PANEL_AUTOREPEAT_EN
    // rcnt counts cycles since the last STEP pulse; first marks the initial delay
    logic [23:0] rcnt [2];
    logic [1:0]  first;

    always_comb begin
        rep_fire = '0;
        for (int j = 0; j < 2; j++) begin
            rep_fire[j] = held[SW_STEPM+j] & ~press[SW_STEPM+j] &
                          (rcnt[j] == (first[j] ? REPEAT_DELAY - 24'd1
                                                : REPEAT_PERIOD - 24'd1));
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            rcnt[0] <= '0;
            rcnt[1] <= '0;
            first   <= 2'b11;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (press[SW_STEPM+j] || !held[SW_STEPM+j]) begin
                    rcnt[j]  <= '0;
                    first[j] <= 1'b1;
                end else if (rep_fire[j]) begin
                    rcnt[j]  <= '0;
                    first[j] <= 1'b0;
                end else if (rcnt[j] != '1) begin
                    rcnt[j] <= rcnt[j] + 24'd1;
                end
            end
        end
    end
`else
    assign rep_fire = 2'b00;
`endif

    // CLEAR level for the cycle being registered; gates all other pulses
    assign clr_next = press[SW_CLEAR] | (clr_cnt > CLW'(1));

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            clr_cnt  <= '0;
            sw_CLEAR <= 1'b0;
            sw_RUN   <= 1'b0;
            sw_HALT  <= 1'b0;
            sw_STEPM <= 1'b0;
            sw_STEPI <= 1'b0;
        end else begin
            if (press[SW_CLEAR]) begin
                clr_cnt <= CLW'(CLEAR_LEN);
            end else if (clr_cnt != '0) begin
                clr_cnt <= clr_cnt - 1'b1;
            end
            sw_CLEAR <= clr_next;
            sw_HALT  <= press[SW_HALT] & ~clr_next;
            sw_RUN   <= press[SW_RUN] & ~press[SW_HALT] & ~clr_next;
            sw_STEPM <= (press[SW_STEPM] | rep_fire[0]) & ~clr_next;
            sw_STEPI <= (press[SW_STEPI] | rep_fire[1]) & ~clr_next;
        end
    end

    assign sw_held = held;

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Self-checking bench for panel_switch_conditioner.
// Random and directed button traffic against a window-based reference model.
module tb_panel_switch_conditioner;
    import panel_pkg::*;

    localparam int D   = 8;
    localparam int CL  = 4;
    localparam int RD  = 20;
    localparam int RP  = 10;
    localparam int N   = 16384;
    localparam int INF = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       RESET;
    logic [4:0] btn_n;
    logic       sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI;
    logic [4:0] sw_held;
    logic [9:0] obs;

    panel_switch_conditioner #(
        .DEBOUNCE_CYCLES(16'd8),
        .CLEAR_LEN      (4),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_PERIOD  (24'd10)
    ) dut (
        .SYSCLK  (clk),
        .RESET   (RESET),
        .btn_n   (btn_n),
        .sw_CLEAR(sw_CLEAR),
        .sw_RUN  (sw_RUN),
        .sw_HALT (sw_HALT),
        .sw_STEPM(sw_STEPM),
        .sw_STEPI(sw_STEPI),
        .sw_held (sw_held)
    );

    always #5 clk = ~clk;

    assign obs = {sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI, sw_held};

    // model state: per-edge history of raw presses and resets
    int         n;
    logic [4:0] rawq [N];
    logic       rstq [N];
    logic [4:0] ev   [N];
    logic [4:0] stab;
    int         last_rst;
    int         clr_end;
    int         nf [2];
    logic [9:0] expv;
    int         checks;
    int         passed;

    // a switch toggles once the last D synchronised samples all differ from it
    function automatic bit window_ok(input int i);
        logic syn;
        for (int k = 0; k < D; k++) begin
            int e;
            e = n - k;
            if (e <= last_rst) return 1'b0;
            syn = rstq[e-1] ? 1'b0 : rawq[e-2][i];
            if (syn == stab[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick(input logic r, input logic [4:0] p);
        logic [4:0] e;
        logic [4:0] hp;
        logic       cn;
        logic [1:0] fire;
        RESET = r;
        btn_n = ~p;
        @(posedge clk);
        rstq[n] = r;
        rawq[n] = r ? 5'b0 : p;
        if (r) begin
            stab     = '0;
            clr_end  = -1;
            nf[0]    = INF;
            nf[1]    = INF;
            last_rst = n;
            ev[n+1]  = '0;
            ev[n+2]  = '0;
            expv     = '0;
        end else begin
            hp = stab;
            for (int i = 0; i < 5; i++) begin
                if (window_ok(i)) begin
                    stab[i] = ~stab[i];
                    if (stab[i]) ev[n+2][i] = 1'b1;
                end
            end
            e = ev[n];
            if (e[SW_CLEAR]) clr_end = n + CL - 1;
            cn = (n <= clr_end);
            fire = 2'b00;
            for (int j = 0; j < 2; j++) begin
                if (!hp[SW_STEPM+j]) nf[j] = INF;
                else if (n == nf[j]) begin
                    fire[j] = 1'b1;
                    nf[j]   = n + RP;
                end
                if (e[SW_STEPM+j]) nf[j] = n + RD;
            end
`ifndef PANEL_AUTOREPEAT_EN
            fire = 2'b00;
`endif
            expv = {cn,
                    e[SW_RUN] & ~e[SW_HALT] & ~cn,
                    e[SW_HALT] & ~cn,
                    (e[SW_STEPM] | fire[0]) & ~cn,
                    (e[SW_STEPI] | fire[1]) & ~cn,
                    stab};
        end
        n++;
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) tick(1'b0, 5'b0);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 5'b11111);
            checks++;
            if (obs !== 10'b0)
                $display("FAIL reset k=%0d got %b want %b", k, obs, 10'b0);
            else passed++;
        end
        idle(4);
        checks++;
        if (obs !== expv)
            $display("FAIL reset_idle got %b want %b", obs, expv);
        else passed++;
    endtask

    task automatic test_clean_press;
        int cnt, at;
        cnt = 0; at = -1;
        for (int k = 0; k < 30; k++) begin
            tick(1'b0, 5'b00010);
            checks++;
            if (obs !== expv)
                $display("FAIL press_model k=%0d got %b want %b", k, obs, expv);
            else passed++;
            if (sw_RUN) begin cnt++; at = k; end
            if (k == 29) begin
                checks++;
                if (sw_held[SW_RUN] !== 1'b1)
                    $display("FAIL press_held got %b want 1", sw_held[SW_RUN]);
                else passed++;
            end
        end
        checks++;
        if (cnt !== 1 || at !== 11)
            $display("FAIL press_pulse got n=%0d at %0d want n=1 at 11", cnt, at);
        else passed++;
        idle(20);
    endtask

    task automatic test_bounce;
        int cnt;
        logic [4:0] p;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            p = (k < 5 || (k >= 10 && k < 15)) ? 5'b00100 : 5'b0;
            tick(1'b0, p);
            checks++;
            if (obs !== expv)
                $display("FAIL bounce_model k=%0d got %b want %b", k, obs, expv);
            else passed++;
            if (sw_HALT) cnt++;
        end
        checks++;
        if (cnt !== 0)
            $display("FAIL bounce_halt got %0d pulses want 0", cnt);
        else passed++;
    endtask

    task automatic test_clear_stretch;
        int ccnt, cfirst, rcnt;
        logic [4:0] p;
        ccnt = 0; cfirst = -1; rcnt = 0;
        for (int k = 0; k < 40; k++) begin
            p = '0;
            if (k < 20) p[SW_CLEAR] = 1'b1;
            if (k >= 2 && k < 22) p[SW_RUN] = 1'b1;
            tick(1'b0, p);
            checks++;
            if (obs !== expv)
                $display("FAIL clear_model k=%0d got %b want %b", k, obs, expv);
            else passed++;
            if (sw_CLEAR) begin
                if (cfirst < 0) cfirst = k;
                ccnt++;
            end
            if (sw_RUN) rcnt++;
        end
        checks++;
        if (ccnt !== 4 || cfirst !== 11)
            $display("FAIL clear_len got %0d at %0d want 4 at 11", ccnt, cfirst);
        else passed++;
        checks++;
        if (rcnt !== 0)
            $display("FAIL clear_suppress got %0d run pulses want 0", rcnt);
        else passed++;
        idle(10);
    endtask

    task automatic test_run_halt;
        int hcnt, hat, rcnt;
        hcnt = 0; hat = -1; rcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 5'b00110);
            checks++;
            if (obs !== expv)
                $display("FAIL rh_model k=%0d got %b want %b", k, obs, expv);
            else passed++;
            if (sw_HALT) begin hcnt++; hat = k; end
            if (sw_RUN) rcnt++;
        end
        checks++;
        if (hcnt !== 1 || hat !== 11 || rcnt !== 0)
            $display("FAIL run_halt got h=%0d@%0d r=%0d want h=1@11 r=0",
                     hcnt, hat, rcnt);
        else passed++;
        idle(20);
    endtask

    task automatic test_reset_mid;
        int cnt, at;
        cnt = 0; at = -1;
        for (int k = 0; k < 100; k++) begin
            tick(k == 9, 5'b10000);
            checks++;
            if (obs !== expv)
                $display("FAIL rmid_model k=%0d got %b want %b", k, obs, expv);
            else passed++;
            if (sw_STEPI) begin cnt++; at = k; end
        end
        checks++;
        if (cnt !== 1 || at !== 21)
            $display("FAIL reset_mid got n=%0d at %0d want n=1 at 21", cnt, at);
        else passed++;
        idle(20);
    endtask

    task automatic test_autorepeat;
        int got [$];
        int want [$];
`ifdef PANEL_AUTOREPEAT_EN
        want = '{11, 31, 41, 51, 61};
`else
        want = '{11};
`endif
        for (int k = 0; k < 100; k++) begin
            tick(1'b0, (k < 60) ? 5'b01000 : 5'b0);
            checks++;
            if (obs !== expv)
                $display("FAIL rep_model k=%0d got %b want %b", k, obs, expv);
            else passed++;
            if (sw_STEPM) got.push_back(k);
        end
        checks++;
        if (got.size() != want.size())
            $display("FAIL rep_count got %0d want %0d", got.size(), want.size());
        else passed++;
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i])
                $display("FAIL rep_at%0d got %0d want %0d", i, got[i], want[i]);
            else passed++;
        end
        idle(20);
    endtask

    task automatic test_random(input int cycles, input int rate);
        logic [4:0] p;
        logic       r;
        p = '0;
        for (int k = 0; k < cycles; k++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(rate - 1, 0) == 0) p[i] = ~p[i];
            r = ($urandom_range(299, 0) == 0);
            tick(r, p);
            checks++;
            if (obs !== expv)
                $display("FAIL random k=%0d got %b want %b", k, obs, expv);
            else passed++;
        end
        idle(30);
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        n        = 4;
        last_rst = 0;
        clr_end  = -1;
        nf[0]    = INF;
        nf[1]    = INF;
        stab     = '0;
        expv     = '0;
        for (int i = 0; i < N; i++) begin
            rawq[i] = '0;
            rstq[i] = 1'b0;
            ev[i]   = '0;
        end
        RESET = 1'b1;
        btn_n = '1;
        test_reset;
        test_clean_press;
        test_bounce;
        test_clear_stretch;
        test_run_halt;
        test_reset_mid;
        test_autorepeat;
        test_random(1500, 10);
        test_random(2000, 40);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
